wvb_wr_ctrl_v2: RTL
===================

# wvb_wr_ctrl_v2

Parametrised waveform-buffer write controller for the mDOM ADC channel path. It sits between the trigger/discriminator logic and the per-channel waveform BRAM plus header FIFO. It generates write strobes and addresses at a configurable sample-packing ratio, and splits long events at a runtime-programmable payload length. It also adds an optional post-event dead-time, and emits one header record per payload.

## Interface
Parameters:
- P_ADR_WIDTH, 12, waveform buffer address width
- P_LTC_WIDTH, 48, local time counter width
- P_DIV_LOG2, 2, log2 of clocks per buffer word (D = 2^P_DIV_LOG2, 1..3 legal)
- P_PRE_WIDTH, 5, pre-trigger config width
- P_POST_WIDTH, 8, post-trigger config width
- P_TEST_WIDTH, 12, test-window config width
- P_SPLIT_WIDTH, 8, max-writes-per-payload config width
- P_HOLD_WIDTH, 16, holdoff config width

Ports:
- clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- ltc  in  P_LTC_WIDTH  local time counter
- trig  in  1  trigger pulse
- trig_src  in  2  0 threshold, 1 software, 2 external, 3 reserved (treated as threshold)
- trig_mode  in  1  0 free-run, 1 armed
- arm  in  1  arm pulse
- overflow_in  in  1  buffer/FIFO full
- local_coinc  in  1  local coincidence flag
- pre_config  in  P_PRE_WIDTH  pre-trigger clocks
- post_config  in  P_POST_WIDTH  post-trigger clocks
- test_config  in  P_TEST_WIDTH  test window clocks
- split_config  in  P_SPLIT_WIDTH  max writes per payload
- hold_config  in  P_HOLD_WIDTH  dead-time clocks
- wvb_wr_addr  out  P_ADR_WIDTH  buffer write address
- wvb_wren  out  1  buffer write strobe
- hdr_wren  out  1  header FIFO write strobe
- hdr_ltc  out  P_LTC_WIDTH  payload start time
- hdr_start_addr, hdr_stop_addr  out  P_ADR_WIDTH each  first and last word address
- hdr_trig_src  out  2  latched trig_src
- hdr_partial, hdr_continued, hdr_coinc  out  1 each  payload flags
- armed, overflow_out, busy  out  1 each  status
- evt_cnt  out  32  completed events

## Operation
- States: IDLE, THRESH, TEST, HOLD.
- Config is latched only in IDLE:
  - pre = max(pre_config, 3)
  - post = max(post_config, 4)
  - test = max(test_config rounded down to a multiple of D, D)
  - split = max(split_config, 1)
- The accept condition, evaluated in IDLE, is: trig, !overflow_in, !overflow_out, and (trig_mode==0 or armed).
- On accept:
  - Phase counter ph is set to 0. ph then increments mod D every cycle outside IDLE and HOLD.
  - wvb_wren = (ph == D-1) in THRESH or TEST.
  - trig_src 1 or 2 goes to TEST. Any other value goes to THRESH, with rem = pre+post.
- THRESH:
  - rem decrements each cycle, saturating at 0.
  - A trig in THRESH reloads rem to pre+post.
  - The final write is the wren with rem == 0 and no trig in the same cycle.
- TEST: the final write is the (test/D)-th wren.
- Split rule:
  - A wren that is not final, has !overflow_in, and has n_writes == split-1 also asserts hdr_wren with hdr_partial=1.
  - The next payload has hdr_continued=1.
  - n_writes clears on every hdr_wren.
- Overflow:
  - overflow_in on a wren cycle forces hdr_wren on that wren.
  - overflow_out then sets sticky; only i_rst clears it.
  - While overflow_out=1, the FSM returns to IDLE and no wren or hdr_wren is issued.
- Header fields:
  - hdr_ltc, hdr_start_addr and hdr_trig_src are latched on accept, and again on the cycle after every split hdr_wren.
  - hdr_stop_addr = wvb_wr_addr during hdr_wren.
  - hdr_coinc is sticky over the payload and clears at payload start.
- On the final hdr_wren, evt_cnt increments (it wraps) and the FSM goes to HOLD, or to IDLE if HOLD is compiled out or hold_config==0.
- armed:
  - Set by arm.
  - Cleared by the final or overflow hdr_wren, not by split hdr_wren.
  - arm wins over a simultaneous clear.
- busy = (state != IDLE).
- Reset values: all outputs 0, state IDLE, wvb_wr_addr 0, evt_cnt 0.

## Timing
- The first wren comes D-1 cycles after the accept cycle.
- wvb_wr_addr increments on the cycle after each wren and wraps at 2^P_ADR_WIDTH with no flag.
- hdr_wren is coincident with the final wren of a payload. Header outputs are valid in that cycle.
- Split payloads are back-to-back with no lost write.
- A trig in IDLE with overflow_in=1 is dropped.
- i_rst mid-event aborts the event with no header and returns everything to reset values in one cycle.

## Configuration
- WVB_HOLDOFF_EN:
  - Defined: after each final hdr_wren the FSM spends hold_config cycles in HOLD. trig is ignored there and busy=1.
  - Undefined: HOLD does not exist, hold_config is unused, and the FSM returns to IDLE directly.

## Test plan
- D=4, pre=3, post=4, single trig at t0 → first wren at t0+3, 2 wrens total (rem reaches 0 at t0+7), one hdr_wren, hdr_start_addr=0, hdr_stop_addr=1, evt_cnt=1.
- Retrigger 3 cycles after the first trig → the window extends; the write count covers pre+post+3 cycles rounded up to a D boundary; one header only.
- TEST with test_config=37, D=4 → 9 wrens, then hdr_wren on the 9th; test_config=2 → 1 wren.
- split_config=3, THRESH event of 8 writes → hdr_wren at writes 3, 6, 8; flags partial,continued = (1,0), (1,1), (0,1).
- overflow_in on the 2nd wren → hdr_wren there, overflow_out=1, no further wren; i_rst clears it.
- With WVB_HOLDOFF_EN and hold_config=10, trig 5 cycles after the final hdr_wren is ignored, and trig 11 cycles after is accepted.

Source files
------------

// File: rtl/wvb_wr_ctrl_v2.sv
// Waveform-buffer write controller for one mDOM ADC channel.
// Generates packed write strobes/addresses, splits long events into payloads of at most
// split_config writes and emits one header record per payload.
// Optional feature macro: WVB_HOLDOFF_EN adds a programmable post-event dead-time (HOLD state).
module wvb_wr_ctrl_v2 #(
  parameter int unsigned P_ADR_WIDTH   = 12,
  parameter int unsigned P_LTC_WIDTH   = 48,
  parameter int unsigned P_DIV_LOG2    = 2,
  parameter int unsigned P_PRE_WIDTH   = 5,
  parameter int unsigned P_POST_WIDTH  = 8,
  parameter int unsigned P_TEST_WIDTH  = 12,
  parameter int unsigned P_SPLIT_WIDTH = 8,
  parameter int unsigned P_HOLD_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic [P_LTC_WIDTH-1:0]   ltc,
  input  logic                     trig,
  input  logic [1:0]               trig_src,
  input  logic                     trig_mode,
  input  logic                     arm,
  input  logic                     overflow_in,
  input  logic                     local_coinc,
  input  logic [P_PRE_WIDTH-1:0]   pre_config,
  input  logic [P_POST_WIDTH-1:0]  post_config,
  input  logic [P_TEST_WIDTH-1:0]  test_config,
  input  logic [P_SPLIT_WIDTH-1:0] split_config,
  input  logic [P_HOLD_WIDTH-1:0]  hold_config,
  output logic [P_ADR_WIDTH-1:0]   wvb_wr_addr,
  output logic                     wvb_wren,
  output logic                     hdr_wren,
  output logic [P_LTC_WIDTH-1:0]   hdr_ltc,
  output logic [P_ADR_WIDTH-1:0]   hdr_start_addr,
  output logic [P_ADR_WIDTH-1:0]   hdr_stop_addr,
  output logic [1:0]               hdr_trig_src,
  output logic                     hdr_partial,
  output logic                     hdr_continued,
  output logic                     hdr_coinc,
  output logic                     armed,
  output logic                     overflow_out,
  output logic                     busy,
  output logic [31:0]              evt_cnt
);

  localparam int unsigned RemW = ((P_PRE_WIDTH > P_POST_WIDTH) ? P_PRE_WIDTH : P_POST_WIDTH) + 1;

`ifdef WVB_HOLDOFF_EN
  typedef enum logic [1:0] {StIdle, StThresh, StTest, StHold} state_e;
`else
  typedef enum logic [1:0] {StIdle, StThresh, StTest} state_e;
`endif

  state_e                   state_q, state_d;
  logic [P_DIV_LOG2-1:0]    ph_q, ph_d;
  logic [RemW-1:0]          win_q, win_d;
  logic [RemW-1:0]          rem_q, rem_d;
  logic [P_TEST_WIDTH-1:0]  wleft_q, wleft_d;
  logic [P_SPLIT_WIDTH-1:0] split_q, split_d;
  logic [P_SPLIT_WIDTH-1:0] nwr_q, nwr_d;
  logic [P_ADR_WIDTH-1:0]   addr_q, addr_d;
  logic [P_LTC_WIDTH-1:0]   hdr_ltc_q, hdr_ltc_d;
  logic [P_ADR_WIDTH-1:0]   hdr_start_q, hdr_start_d;
  logic [1:0]               hdr_src_q, hdr_src_d;
  logic                     coinc_q, coinc_d;
  logic                     cont_q, cont_d;
  logic                     relatch_q, relatch_d;
  logic                     armed_q, armed_d;
  logic                     ovf_q, ovf_d;
  logic [31:0]              evt_q, evt_d;
`ifdef WVB_HOLDOFF_EN
  logic [P_HOLD_WIDTH-1:0]  hold_q, hold_d;
  logic [P_HOLD_WIDTH-1:0]  hold_cnt_q, hold_cnt_d;
`else
  logic                     unused_hold;
  assign unused_hold = ^hold_config;
`endif

  logic                     active, accept, wren, final_wr, split_hit, ovf_hit, hdr_hit;
  logic [P_PRE_WIDTH-1:0]   pre_eff;
  logic [P_POST_WIDTH-1:0]  post_eff;
  logic [RemW-1:0]          win_new;
  logic [P_TEST_WIDTH-1:0]  test_words;
  logic [P_SPLIT_WIDTH-1:0] split_new;

  // Clamp runtime configuration to legal minimums; only consumed on accept.
  always_comb begin
    pre_eff    = (pre_config < P_PRE_WIDTH'(3)) ? P_PRE_WIDTH'(3) : pre_config;
    post_eff   = (post_config < P_POST_WIDTH'(4)) ? P_POST_WIDTH'(4) : post_config;
    win_new    = RemW'(pre_eff) + RemW'(post_eff);
    test_words = test_config >> P_DIV_LOG2;
    if (test_words == '0) test_words = P_TEST_WIDTH'(1);
    split_new  = (split_config == '0) ? P_SPLIT_WIDTH'(1) : split_config;
  end

  // Write/header strobe decode for the current cycle.
  always_comb begin
    active    = (state_q == StThresh) || (state_q == StTest);
    accept    = (state_q == StIdle) && trig && !overflow_in && !ovf_q && (!trig_mode || armed_q);
    wren      = active && (ph_q == '1) && !ovf_q;
    if (state_q == StThresh) final_wr = wren && (rem_q == '0) && !trig;
    else                     final_wr = wren && (wleft_q == P_TEST_WIDTH'(1));
    ovf_hit   = wren && overflow_in;
    split_hit = wren && !final_wr && !overflow_in && (nwr_q == (split_q - P_SPLIT_WIDTH'(1)));
    hdr_hit   = final_wr || split_hit || ovf_hit;
  end

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    win_d       = win_q;
    rem_d       = rem_q;
    wleft_d     = wleft_q;
    split_d     = split_q;
    nwr_d       = nwr_q;
    addr_d      = addr_q;
    hdr_ltc_d   = hdr_ltc_q;
    hdr_start_d = hdr_start_q;
    hdr_src_d   = hdr_src_q;
    coinc_d     = coinc_q;
    cont_d      = cont_q;
    relatch_d   = relatch_q;
    ovf_d       = ovf_q;
    evt_d       = evt_q;
`ifdef WVB_HOLDOFF_EN
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (accept) begin
          // The accept cycle is phase 0 and the first cycle of the pre+post window.
          ph_d        = P_DIV_LOG2'(1);
          win_d       = win_new;
          rem_d       = win_new - RemW'(1);
          wleft_d     = test_words;
          split_d     = split_new;
          nwr_d       = '0;
          hdr_ltc_d   = ltc;
          hdr_start_d = addr_q;
          hdr_src_d   = trig_src;
          coinc_d     = local_coinc;
          cont_d      = 1'b0;
          relatch_d   = 1'b0;
`ifdef WVB_HOLDOFF_EN
          hold_d      = hold_config;
`endif
          state_d     = ((trig_src == 2'd1) || (trig_src == 2'd2)) ? StTest : StThresh;
        end
      end
      StThresh, StTest: begin
        if (ovf_q) begin
          state_d = StIdle;
        end else begin
          ph_d      = ph_q + P_DIV_LOG2'(1);
          coinc_d   = coinc_q | local_coinc;
          relatch_d = 1'b0;
          if (state_q == StThresh) begin
            // A retrigger counts as the first cycle of a fresh window, like the accept.
            if (trig)               rem_d = win_q - RemW'(1);
            else if (rem_q != '0)   rem_d = rem_q - RemW'(1);
          end
          if (relatch_q) begin
            hdr_ltc_d   = ltc;
            hdr_start_d = addr_q;
            hdr_src_d   = trig_src;
          end
          if (wren) begin
            addr_d  = addr_q + P_ADR_WIDTH'(1);
            nwr_d   = nwr_q + P_SPLIT_WIDTH'(1);
            wleft_d = wleft_q - P_TEST_WIDTH'(1);
          end
          if (hdr_hit) begin
            nwr_d   = '0;
            coinc_d = 1'b0;
          end
          if (split_hit) begin
            relatch_d = 1'b1;
            cont_d    = 1'b1;
          end
          if (final_wr) begin
            evt_d = evt_q + 32'd1;
`ifdef WVB_HOLDOFF_EN
            if (hold_q != '0) begin
              state_d    = StHold;
              hold_cnt_d = hold_q - P_HOLD_WIDTH'(1);
            end else begin
              state_d    = StIdle;
            end
`else
            state_d = StIdle;
`endif
          end
          if (ovf_hit) begin
            ovf_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
`ifdef WVB_HOLDOFF_EN
      StHold: begin
        if (hold_cnt_q == '0) state_d = StIdle;
        else                  hold_cnt_d = hold_cnt_q - P_HOLD_WIDTH'(1);
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Arm flag: split headers leave it alone, a simultaneous arm beats the clear.
  always_comb begin
    armed_d = armed_q;
    if (hdr_hit && !split_hit) armed_d = 1'b0;
    if (arm)                   armed_d = 1'b1;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      ph_q        <= '0;
      win_q       <= '0;
      rem_q       <= '0;
      wleft_q     <= '0;
      split_q     <= '0;
      nwr_q       <= '0;
      addr_q      <= '0;
      hdr_ltc_q   <= '0;
      hdr_start_q <= '0;
      hdr_src_q   <= '0;
      coinc_q     <= 1'b0;
      cont_q      <= 1'b0;
      relatch_q   <= 1'b0;
      armed_q     <= 1'b0;
      ovf_q       <= 1'b0;
      evt_q       <= '0;
`ifdef WVB_HOLDOFF_EN
      hold_q      <= '0;
      hold_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      win_q       <= win_d;
      rem_q       <= rem_d;
      wleft_q     <= wleft_d;
      split_q     <= split_d;
      nwr_q       <= nwr_d;
      addr_q      <= addr_d;
      hdr_ltc_q   <= hdr_ltc_d;
      hdr_start_q <= hdr_start_d;
      hdr_src_q   <= hdr_src_d;
      coinc_q     <= coinc_d;
      cont_q      <= cont_d;
      relatch_q   <= relatch_d;
      armed_q     <= armed_d;
      ovf_q       <= ovf_d;
      evt_q       <= evt_d;
`ifdef WVB_HOLDOFF_EN
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign wvb_wr_addr    = addr_q;
  assign wvb_wren       = wren;
  assign hdr_wren       = hdr_hit;
  assign hdr_ltc        = hdr_ltc_q;
  assign hdr_start_addr = hdr_start_q;
  assign hdr_stop_addr  = addr_q;
  assign hdr_trig_src   = hdr_src_q;
  assign hdr_partial    = split_hit;
  assign hdr_continued  = cont_q;
  assign hdr_coinc      = coinc_q;
  assign armed          = armed_q;
  assign overflow_out   = ovf_q;
  assign busy           = (state_q != StIdle);
  assign evt_cnt        = evt_q;

endmodule
